// File: rtl/display_bus_reader.sv
// Monitor for the multiplexed 7-segment display bus: samples anode/segment lines,
// decodes each settled glyph back to BCD and rebuilds the 16-bit displayed value.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | waiting for all four digit slots to be captured
// CONVERT | four multiply-by-ten/add steps over the snapshot, thousands first
// DONE    | one cycle after the result is published, then back to COLLECT
module display_bus_reader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg_in,
    output logic [15:0] num_out,
    output logic        num_valid,
    output logic        glyph_err,
    output logic        disp_on
);

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic [3:0]       an_p;
    logic [6:0]       seg_p;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             change;
    logic             accept;

    logic [3:0]       captured;
    logic [3:0]       captured_next;
    logic [3:0]       err_r;
    logic [3:0]       err_next;
    logic [3:0]       digit_r [4];

    logic             one_low;
    logic             all_high;
    logic [1:0]       slot;
    logic [4:0]       dec;

    state_t           state;
    logic [1:0]       step;
    logic [13:0]      acc;
    logic [13:0]      acc_next;
    logic [3:0]       cur_digit;
    logic [3:0]       snap_digit [4];
    logic [3:0]       snap_err;
    logic             frame_take;

    // Returns {err, digit}; blank decodes to a clean zero.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b0, 4'd0};
            7'b1111001: r = {1'b0, 4'd1};
            7'b0100100: r = {1'b0, 4'd2};
            7'b0110000: r = {1'b0, 4'd3};
            7'b0011001: r = {1'b0, 4'd4};
            7'b0010010: r = {1'b0, 4'd5};
            7'b0000010: r = {1'b0, 4'd6};
            7'b1111000: r = {1'b0, 4'd7};
            7'b0000000: r = {1'b0, 4'd8};
            7'b0010000: r = {1'b0, 4'd9};
            7'b1111111: r = {1'b0, 4'd0};
            default:    r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    assign change = (an_q != an_p) || (seg_q != seg_p);

    always_comb begin
        if (change) begin
            cnt_next = CNT_ONE;
        end else if (cnt == {CNT_W{1'b1}}) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_ONE;
        end
    end

    // Fires once per dwell: the guard stops a counter parked at SETTLE re-firing.
    assign accept = (cnt_next == SETTLE) && (change || (cnt != SETTLE));

    always_comb begin
        one_low = 1'b0;
        slot    = 2'd0;
        case (an_q)
            4'b1110: begin one_low = 1'b1; slot = 2'd0; end
            4'b1101: begin one_low = 1'b1; slot = 2'd1; end
            4'b1011: begin one_low = 1'b1; slot = 2'd2; end
            4'b0111: begin one_low = 1'b1; slot = 2'd3; end
            default: ;
        endcase
    end

    assign all_high   = (an_q == 4'b1111);
    assign dec        = decode_glyph(seg_q);
    assign frame_take = (state == COLLECT) && (captured == 4'hF);

    // New captures land in the flags even on the cycle the FSM takes a frame.
    always_comb begin
        captured_next = captured;
        err_next      = err_r;
        if (frame_take) begin
            captured_next = 4'h0;
        end
        if (accept && all_high) begin
            captured_next = 4'h0;
            err_next      = 4'h0;
        end
        if (accept && one_low) begin
            captured_next[slot] = 1'b1;
            err_next[slot]      = dec[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q     <= 4'h0;
            seg_q    <= 7'h00;
            an_p     <= 4'h0;
            seg_p    <= 7'h00;
            cnt      <= '0;
            captured <= 4'h0;
            err_r    <= 4'h0;
            disp_on  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_r[i] <= 4'd0;
            end
        end else begin
            an_q     <= an;
            seg_q    <= seg_in;
            an_p     <= an_q;
            seg_p    <= seg_q;
            cnt      <= cnt_next;
            captured <= captured_next;
            err_r    <= err_next;
            if (accept) begin
                disp_on <= !all_high;
            end
            if (accept && one_low) begin
                digit_r[slot] <= dec[3:0];
            end
        end
    end

    assign cur_digit = snap_digit[2'd3 - step];
    assign acc_next  = (acc << 3) + (acc << 1) + {10'd0, cur_digit};

    // The result is published on the last CONVERT edge so DONE is the pulse cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            step      <= 2'd0;
            acc       <= 14'd0;
            snap_err  <= 4'h0;
            num_out   <= 16'd0;
            num_valid <= 1'b0;
            glyph_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_digit[i] <= 4'd0;
            end
        end else begin
            num_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (frame_take) begin
                        for (int i = 0; i < 4; i++) begin
                            snap_digit[i] <= digit_r[i];
                        end
                        snap_err <= err_r;
                        acc      <= 14'd0;
                        step     <= 2'd0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        num_out   <= {2'b00, acc_next};
                        glyph_err <= |snap_err;
                        num_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_bus_reader.sv
// Directed bench for display_bus_reader: drives glyph frames on the anode/segment
// bus and compares the reconstructed value, error flag, pulse timing and disp_on.
module tb_display_bus_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg_in;
    logic [15:0] num_out;
    logic        num_valid;
    logic        glyph_err;
    logic        disp_on;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int valid_cyc = -1;
    int last_set = 0;

    logic [6:0] glyph [10];

    display_bus_reader #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an),
        .seg_in    (seg_in),
        .num_out   (num_out),
        .num_valid (num_valid),
        .glyph_err (glyph_err),
        .disp_on   (disp_on)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (num_valid === 1'b1) begin
            pulses++;
            valid_cyc = cyc;
        end
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an     = a;
        seg_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        hold(4'b1110, s0, 8);
        hold(4'b1101, s1, 8);
        hold(4'b1011, s2, 8);
        last_set = cyc;
        hold(4'b0111, s3, 8);
    endtask

    task automatic test_reset;
        checks++;
        if (num_out !== 16'd0) begin
            errors++; $display("FAIL reset_num_out got %0d want 0", num_out);
        end
        checks++;
        if (num_valid !== 1'b0) begin
            errors++; $display("FAIL reset_num_valid got %b want 0", num_valid);
        end
        checks++;
        if (glyph_err !== 1'b0) begin
            errors++; $display("FAIL reset_glyph_err got %b want 0", glyph_err);
        end
        checks++;
        if (disp_on !== 1'b0) begin
            errors++; $display("FAIL reset_disp_on got %b want 0", disp_on);
        end
    endtask

    task automatic test_basic;
        int p0;
        p0 = pulses;
        send_frame(glyph[4], glyph[3], glyph[2], glyph[1]);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd1234) begin
            errors++; $display("FAIL basic_value got %0d want 1234", num_out);
        end
        checks++;
        if (glyph_err !== 1'b0) begin
            errors++; $display("FAIL basic_err got %b want 0", glyph_err);
        end
        checks++;
        if (pulses !== p0 + 1) begin
            errors++; $display("FAIL basic_pulses got %0d want %0d", pulses - p0, 1);
        end
        checks++;
        if (valid_cyc !== last_set + 10) begin
            errors++; $display("FAIL basic_latency got %0d want %0d", valid_cyc, last_set + 10);
        end
        checks++;
        if (disp_on !== 1'b1) begin
            errors++; $display("FAIL basic_disp_on got %b want 1", disp_on);
        end
    endtask

    task automatic test_nines_blank;
        int p0;
        p0 = pulses;
        send_frame(glyph[9], glyph[9], glyph[9], glyph[9]);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd9999) begin
            errors++; $display("FAIL nines_value got %0d want 9999", num_out);
        end
        send_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd0) begin
            errors++; $display("FAIL blank_value got %0d want 0", num_out);
        end
        checks++;
        if (glyph_err !== 1'b0) begin
            errors++; $display("FAIL blank_err got %b want 0", glyph_err);
        end
        checks++;
        if (pulses !== p0 + 2) begin
            errors++; $display("FAIL nines_blank_pulses got %0d want 2", pulses - p0);
        end
    endtask

    task automatic test_glyph_err;
        send_frame(glyph[5], 7'b0001000, glyph[5], glyph[5]);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd5505) begin
            errors++; $display("FAIL hex_value got %0d want 5505", num_out);
        end
        checks++;
        if (glyph_err !== 1'b1) begin
            errors++; $display("FAIL hex_err got %b want 1", glyph_err);
        end
        send_frame(glyph[5], glyph[0], glyph[0], glyph[0]);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd5) begin
            errors++; $display("FAIL clean_value got %0d want 5", num_out);
        end
        checks++;
        if (glyph_err !== 1'b0) begin
            errors++; $display("FAIL clean_err got %b want 0", glyph_err);
        end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = pulses;
        hold(4'b1110, glyph[7], 8);
        hold(4'b1110, glyph[8], 3);
        hold(4'b1101, glyph[6], 8);
        hold(4'b1100, glyph[1], 10);
        hold(4'b1011, glyph[0], 8);
        hold(4'b0111, glyph[2], 8);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd2067) begin
            errors++; $display("FAIL glitch_value got %0d want 2067", num_out);
        end
        checks++;
        if (pulses !== p0 + 1) begin
            errors++; $display("FAIL glitch_pulses got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_blank_abort;
        int p0;
        p0 = pulses;
        hold(4'b1011, glyph[9], 8);
        hold(4'b0111, glyph[9], 8);
        hold(4'b1111, 7'h7F, 6);
        checks++;
        if (disp_on !== 1'b0) begin
            errors++; $display("FAIL abort_disp_on got %b want 0", disp_on);
        end
        hold(4'b1110, glyph[2], 8);
        hold(4'b1101, glyph[4], 8);
        repeat (4) @(negedge clk);
        checks++;
        if (pulses !== p0) begin
            errors++; $display("FAIL abort_no_pulse got %0d want 0", pulses - p0);
        end
        hold(4'b1011, glyph[0], 8);
        hold(4'b0111, glyph[0], 8);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd42) begin
            errors++; $display("FAIL abort_value got %0d want 42", num_out);
        end
        checks++;
        if (disp_on !== 1'b1) begin
            errors++; $display("FAIL abort_disp_on_back got %b want 1", disp_on);
        end
        checks++;
        if (pulses !== p0 + 1) begin
            errors++; $display("FAIL abort_pulses got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_reset_convert;
        int p0;
        int s3;
        p0 = pulses;
        hold(4'b1110, glyph[9], 8);
        hold(4'b1101, glyph[9], 8);
        hold(4'b1011, glyph[9], 8);
        s3 = cyc;
        hold(4'b0111, glyph[9], 7);
        if (cyc !== s3 + 7) $display("note: reset point drifted to cycle %0d", cyc);
        rst_n = 1'b0;
        #1;
        checks++;
        if (num_out !== 16'd0) begin
            errors++; $display("FAIL rstconv_num_out got %0d want 0", num_out);
        end
        checks++;
        if (disp_on !== 1'b0) begin
            errors++; $display("FAIL rstconv_disp_on got %b want 0", disp_on);
        end
        an     = 4'b1111;
        seg_in = 7'h7F;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (pulses !== p0) begin
            errors++; $display("FAIL rstconv_no_pulse got %0d want 0", pulses - p0);
        end
        checks++;
        if (num_out !== 16'd0) begin
            errors++; $display("FAIL rstconv_after_num_out got %0d want 0", num_out);
        end
        checks++;
        if (glyph_err !== 1'b0) begin
            errors++; $display("FAIL rstconv_glyph_err got %b want 0", glyph_err);
        end
        send_frame(glyph[1], glyph[7], glyph[8], glyph[0]);
        repeat (4) @(negedge clk);
        checks++;
        if (num_out !== 16'd871) begin
            errors++; $display("FAIL rstconv_recover got %0d want 871", num_out);
        end
        checks++;
        if (pulses !== p0 + 1) begin
            errors++; $display("FAIL rstconv_recover_pulses got %0d want 1", pulses - p0);
        end
    endtask

    initial begin
        glyph[0] = 7'b1000000;
        glyph[1] = 7'b1111001;
        glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000;
        glyph[4] = 7'b0011001;
        glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010;
        glyph[7] = 7'b1111000;
        glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
        rst_n  = 1'b0;
        an     = 4'b1111;
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        test_reset;
        test_basic;
        test_nines_blank;
        test_glyph_err;
        test_glitch;
        test_blank_abort;
        test_reset_convert;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
